regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, meaning the number of write-back requesters (legal range 2..8).
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port req_valid_i, input, NREQ, where bit k is requester k's write request.
REQ-005 The block SHALL have port req_addr_i, input, 5*NREQ, where bits [5k+4:5k] are requester k's destination register.
REQ-006 The block SHALL have port req_data_i, input, 32*NREQ, where bits [32k+31:32k] are requester k's write data.
REQ-007 The block SHALL have port req_ready_o, output, NREQ, where bit k is the grant/accept for requester k.
REQ-008 The block SHALL have ports rd_addr_o (5), rd_data_o (32) and rd_wren_o (1), outputs, which drive the register file's single write port.
REQ-009 The block SHALL have ports rs1_addr_i and rs2_addr_i, inputs, 5 each, which are the register-file read addresses being used this cycle.
REQ-010 The block SHALL have ports rs1_fwd_o and rs2_fwd_o, outputs, 1 each, which are bypass-select flags (consumer selects rd_data_o when set).

Function
REQ-011 A transfer SHALL occur for requester k in a cycle when req_valid_i[k] and req_ready_o[k] are both 1; at most one transfer SHALL occur per cycle.
REQ-012 req_ready_o SHALL be combinational, one-hot or zero, and set only for the granted requester; ready SHALL NOT depend on any downstream signal, because the register file always accepts.
REQ-013 Grant SHALL be round-robin: the search starts at (last_ptr+1) mod NREQ, ascending with wrap, and the first requester with valid=1 wins.
REQ-014 last_ptr SHALL load the granted index only on a transfer; with no transfer it SHALL hold.
REQ-015 On a transfer at edge N, rd_addr_o/rd_data_o SHALL load the winner's addr/data, and rd_wren_o SHALL be 1 during cycle N+1 (register written at edge N+1) unless addr = 0.
REQ-016 A request with addr = 0 SHALL be accepted (ready=1, pointer advances); rd_addr_o/rd_data_o SHALL load, and rd_wren_o SHALL be 0 the next cycle.
REQ-017 In a cycle with no transfer, rd_wren_o SHALL be 0 the next cycle, and rd_addr_o/rd_data_o SHALL hold their values.
REQ-018 Writes SHALL reach the register file in grant order; a later grant to the same register SHALL overwrite an earlier one.
REQ-019 Requesters SHALL hold valid, addr and data stable until accepted; dropping valid before ready is permitted, and the block SHALL then not grant that requester.
REQ-020 rsX_fwd_o SHALL equal rd_wren_o AND (rd_addr_o == rsX_addr_i) AND (rsX_addr_i != 0), combinationally, for X = 1, 2.
REQ-021 While all valid bits are 0, req_ready_o SHALL be all 0.

Reset
REQ-022 While rst_i = 1 at a rising edge: rd_wren_o, rd_addr_o and rd_data_o SHALL become 0, and last_ptr SHALL become NREQ-1 so that requester 0 has top priority.
REQ-023 While rst_i = 1, req_ready_o SHALL be all 0 and no transfer SHALL occur.
REQ-024 Reset mid-operation SHALL discard any pending write in the output stage; rd_wren_o SHALL be 0 in the cycle after the reset edge.
REQ-025 rs1_fwd_o and rs2_fwd_o SHALL be 0 whenever rd_wren_o = 0.

Verification
REQ-026 Reset, then valid=3'b111 with addrs 5/6/7 held for 3 cycles: grants SHALL go 0, 1, 2, and rd_wren_o SHALL be 1 with rd_addr_o = 5, 6, 7 on cycles 2-4.
REQ-027 Requester 1 only, addr=0, data=0xDEADBEEF: req_ready_o=3'b010 and the next-cycle rd_wren_o=0; a following request to addr 3 from requesters 1 and 2 SHALL be granted to requester 2 first.
REQ-028 Requesters 0 and 2 both write x9 (data 0x11, 0x22) with pointer=0: requester 2 SHALL be granted first, and x9 SHALL end at 0x11.
REQ-029 rd_wren_o=1, rd_addr_o=4, rs1_addr_i=4, rs2_addr_i=0: rs1_fwd_o=1 and rs2_fwd_o=0; with rd_addr_o=0 and rs1_addr_i=0, both flags SHALL be 0.
REQ-030 Transfer at edge N with rst_i=1 at edge N+1: rd_wren_o=0 after edge N+1, no write reaches the register file, and the next grant SHALL go to requester 0.
REQ-031 Random valid/addr/data for 10k cycles against a scoreboard: one transfer per cycle maximum, no starvation beyond NREQ-1 foreign grants, and write order matching grant order.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that merges NREQ write-back requesters onto the single
// register-file write port, with a registered output stage and bypass-select
// flags for the two register-file read addresses.
module regfile_wb_arbiter #(
    parameter int NREQ = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [5*NREQ-1:0]    req_addr_i,
    input  logic [32*NREQ-1:0]   req_data_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic [4:0]           rd_addr_o,
    output logic [31:0]          rd_data_o,
    output logic                 rd_wren_o,
    input  logic [4:0]           rs1_addr_i,
    input  logic [4:0]           rs2_addr_i,
    output logic                 rs1_fwd_o,
    output logic                 rs2_fwd_o
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] last_ptr_q, last_ptr_d;
    logic [4:0]    addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          wren_q, wren_d;

    logic [PW-1:0] gnt_idx;
    logic          gnt_any;
    logic [PW:0]   cand;
    logic [4:0]    gnt_addr;
    logic [31:0]   gnt_data;
    logic          xfer;

    // Round-robin search: start one past the last winner, ascend with wrap.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = {1'b0, last_ptr_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!gnt_any && req_valid_i[cand[PW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[PW-1:0];
            end
        end
    end

    assign gnt_addr = req_addr_i[int'(gnt_idx)*5 +: 5];
    assign gnt_data = req_data_i[int'(gnt_idx)*32 +: 32];
    // No grant is issued while reset is held, so nothing can be accepted then.
    assign xfer     = gnt_any && !rst_i;

    // One-hot ready for the winner; the register file never back-pressures.
    always_comb begin
        req_ready_o = '0;
        if (xfer) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    // Next-state for the output stage and the round-robin pointer.
    always_comb begin
        last_ptr_d = last_ptr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wren_d     = 1'b0;
        if (rst_i) begin
            last_ptr_d = PW'(NREQ-1);
            addr_d     = '0;
            data_d     = '0;
        end else if (xfer) begin
            last_ptr_d = gnt_idx;
            addr_d     = gnt_addr;
            data_d     = gnt_data;
            wren_d     = (gnt_addr != 5'd0);
        end
    end

    // State registers; reset leaves requester 0 with top priority.
    always_ff @(posedge clk_i) begin
        last_ptr_q <= last_ptr_d;
        addr_q     <= addr_d;
        data_q     <= data_d;
        wren_q     <= wren_d;
    end

    // Masking with rst_i drops a pending write whose write edge coincides with reset.
    assign rd_wren_o = wren_q && !rst_i;
    assign rd_addr_o = addr_q;
    assign rd_data_o = data_q;

    assign rs1_fwd_o = rd_wren_o && (rd_addr_o == rs1_addr_i) && (rs1_addr_i != 5'd0);
    assign rs2_fwd_o = rd_wren_o && (rd_addr_o == rs2_addr_i) && (rs2_addr_i != 5'd0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations
// followed by a long randomized run against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    valid;
    logic [5*N-1:0]  addr;
    logic [32*N-1:0] data;
    logic [N-1:0]    req_ready_o;
    logic [4:0]      rd_addr_o;
    logic [31:0]     rd_data_o;
    logic            rd_wren_o;
    logic [4:0]      rs1, rs2;
    logic            rs1_fwd_o, rs2_fwd_o;

    int ncmp = 0;
    int nfail = 0;

    // Behavioural model state
    int          m_last;
    bit          m_wren;
    bit [4:0]    m_addr;
    bit [31:0]   m_data;
    bit [31:0]   mrf [32];
    int          waitc [N];

    // Register file fed by the DUT write port
    logic        rf_clr;
    logic [31:0] drf [32];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NREQ(N)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(valid),
        .req_addr_i (addr),
        .req_data_i (data),
        .req_ready_o(req_ready_o),
        .rd_addr_o  (rd_addr_o),
        .rd_data_o  (rd_data_o),
        .rd_wren_o  (rd_wren_o),
        .rs1_addr_i (rs1),
        .rs2_addr_i (rs2),
        .rs1_fwd_o  (rs1_fwd_o),
        .rs2_fwd_o  (rs2_fwd_o)
    );

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) drf[i] <= 32'd0;
        end else if (rd_wren_o) begin
            drf[rd_addr_o] <= rd_data_o;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // First valid requester at or after last+1, wrapping; -1 if none or in reset.
    function automatic int model_grant(input logic [N-1:0] v, input int last, input bit r);
        if (r) return -1;
        for (int i = 1; i <= N; i++) begin
            if (v[(last + i) % N] === 1'b1) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic setreq(input int k, input logic v, input logic [4:0] a, input logic [31:0] d);
        valid[k]        = v;
        addr[5*k +: 5]  = a;
        data[32*k +: 32] = d;
    endtask

    task automatic compare_now();
        int g;
        logic [N-1:0] er;
        bit ew;
        g  = model_grant(valid, m_last, rst);
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        ew = m_wren && !rst;
        chk("ready", 32'(req_ready_o), 32'(er));
        chk("wren",  32'(rd_wren_o), 32'(ew));
        chk("rdaddr", 32'(rd_addr_o), 32'(m_addr));
        chk("rddata", rd_data_o, m_data);
        chk("fwd1", 32'(rs1_fwd_o), 32'(ew && m_addr == rs1 && rs1 != 5'd0));
        chk("fwd2", 32'(rs2_fwd_o), 32'(ew && m_addr == rs2 && rs2 != 5'd0));
    endtask

    task automatic advance(output int g);
        g = model_grant(valid, m_last, rst);
        for (int k = 0; k < N; k++) begin
            if (rst || !valid[k] || req_ready_o[k]) begin
                waitc[k] = 0;
            end else if (req_ready_o != '0) begin
                waitc[k]++;
                chk("starve", 32'(waitc[k] <= N-1), 32'd1);
            end
        end
        @(posedge clk);
        if (m_wren && !rst) mrf[m_addr] = m_data;
        if (rst) begin
            m_wren = 1'b0; m_addr = '0; m_data = '0; m_last = N-1;
        end else if (g >= 0) begin
            m_addr = addr[5*g +: 5];
            m_data = data[32*g +: 32];
            m_wren = (m_addr != 5'd0);
            m_last = g;
        end else begin
            m_wren = 1'b0;
        end
        #1;
    endtask

    task automatic step();
        int g;
        @(negedge clk);
        compare_now();
        advance(g);
    endtask

    initial begin
        int g;
        rst = 1'b1; rf_clr = 1'b1;
        valid = '0; addr = '0; data = '0; rs1 = '0; rs2 = '0;
        m_wren = 1'b0; m_addr = '0; m_data = '0; m_last = N-1;
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        for (int k = 0; k < N; k++) waitc[k] = 0;
        @(posedge clk); #1;
        rf_clr = 1'b0;

        // Reset held with all requesters asserting: nothing granted, outputs zero
        valid = 3'b111;
        @(negedge clk); compare_now();
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_wren", 32'(rd_wren_o), 32'd0);
        chk("rst_addr", 32'(rd_addr_o), 32'd0);
        advance(g);

        // Three requesters held: grants 0,1,2 and writes to 5,6,7
        rst = 1'b0;
        setreq(0, 1'b1, 5'd5, 32'hA0); setreq(1, 1'b1, 5'd6, 32'hA1); setreq(2, 1'b1, 5'd7, 32'hA2);
        @(negedge clk); compare_now();
        chk("rr_g0", 32'(req_ready_o), 32'b001);
        advance(g);
        @(negedge clk); compare_now();
        chk("rr_g1", 32'(req_ready_o), 32'b010);
        chk("rr_w5", 32'({rd_wren_o, rd_addr_o}), 32'({1'b1, 5'd5}));
        advance(g);
        @(negedge clk); compare_now();
        chk("rr_g2", 32'(req_ready_o), 32'b100);
        chk("rr_w6", 32'({rd_wren_o, rd_addr_o}), 32'({1'b1, 5'd6}));
        advance(g);
        valid = '0;
        @(negedge clk); compare_now();
        chk("idle_ready", 32'(req_ready_o), 32'd0);
        chk("rr_w7", 32'({rd_wren_o, rd_addr_o}), 32'({1'b1, 5'd7}));
        advance(g);

        // Write to x0 is accepted but not written; then 1 and 2 compete for x3
        setreq(1, 1'b1, 5'd0, 32'hDEADBEEF);
        @(negedge clk); compare_now();
        chk("x0_ready", 32'(req_ready_o), 32'b010);
        advance(g);
        setreq(1, 1'b1, 5'd3, 32'h33); setreq(2, 1'b1, 5'd3, 32'h44);
        @(negedge clk); compare_now();
        chk("x0_wren", 32'(rd_wren_o), 32'd0);
        chk("x0_data", rd_data_o, 32'hDEADBEEF);
        chk("x3_first", 32'(req_ready_o), 32'b100);
        advance(g);
        setreq(2, 1'b0, 5'd0, 32'h0);
        step(); valid = '0; step(); step();
        chk("x3_final", drf[3], 32'h33);

        // Bring pointer to 0, then 0 and 2 both write x9
        setreq(0, 1'b1, 5'd1, 32'h1);
        step();
        setreq(0, 1'b1, 5'd9, 32'h11); setreq(2, 1'b1, 5'd9, 32'h22);
        @(negedge clk); compare_now();
        chk("x9_first", 32'(req_ready_o), 32'b100);
        advance(g);
        setreq(2, 1'b0, 5'd0, 32'h0);
        @(negedge clk); compare_now();
        chk("x9_second", 32'(req_ready_o), 32'b001);
        advance(g);
        valid = '0; step(); step();
        chk("x9_final", drf[9], 32'h11);

        // Bypass flags
        setreq(1, 1'b1, 5'd4, 32'h44);
        step();
        valid = '0; rs1 = 5'd4; rs2 = 5'd0;
        @(negedge clk); compare_now();
        chk("fwd_rs1", 32'(rs1_fwd_o), 32'd1);
        chk("fwd_rs2", 32'(rs2_fwd_o), 32'd0);
        advance(g);
        setreq(2, 1'b1, 5'd0, 32'h5);
        step();
        valid = '0; rs1 = 5'd0; rs2 = 5'd0;
        @(negedge clk); compare_now();
        chk("fwd_x0", 32'({rs1_fwd_o, rs2_fwd_o}), 32'd0);
        advance(g);

        // Transfer immediately followed by reset: write is dropped
        setreq(0, 1'b1, 5'd12, 32'hC0FFEE);
        step();
        valid = '0; rst = 1'b1; rs1 = 5'd12;
        @(negedge clk); compare_now();
        chk("rstmid_wren", 32'(rd_wren_o), 32'd0);
        chk("rstmid_fwd", 32'(rs1_fwd_o), 32'd0);
        advance(g);
        rst = 1'b0;
        setreq(0, 1'b1, 5'd1, 32'h1); setreq(1, 1'b1, 5'd2, 32'h2); setreq(2, 1'b1, 5'd3, 32'h3);
        @(negedge clk); compare_now();
        chk("rstmid_g0", 32'(req_ready_o), 32'b001);
        advance(g);
        valid = '0; step(); step();
        chk("rstmid_x12", drf[12], 32'd0);

        // Randomized traffic; requesters hold until accepted, occasionally withdraw
        g = -1;
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!(valid[k] && g != k && ($urandom % 16) != 0)) begin
                    setreq(k, 1'($urandom % 2), 5'($urandom % 32), $urandom);
                end
            end
            rst = (($urandom % 400) == 0);
            rs1 = ($urandom % 2) ? m_addr : 5'($urandom % 32);
            rs2 = ($urandom % 2) ? m_addr : 5'($urandom % 32);
            @(negedge clk);
            compare_now();
            advance(g);
        end
        rst = 1'b0; valid = '0;
        step(); step();
        for (int i = 0; i < 32; i++) chk("rf_final", drf[i], mrf[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
